// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU/PC/operand-select codes and the packed control-word layout.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMMEXEC  = 4'd10,
    S_IMMWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch target; S_FETCH doubles as the "undecodable" marker.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 decode_target = S_EXEC;
      OP_LW, OP_SW:             decode_target = S_MEMADDR;
      OP_BEQ:                   decode_target = S_BRANCH;
      OP_J:                     decode_target = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI: decode_target = S_IMMEXEC;
      default:                  decode_target = S_FETCH;
    endcase
  endfunction

  function automatic logic is_imm_logic(input logic [5:0] op);
    is_imm_logic = (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Output decoder: maps registered state (+opcode, +mem_ready in FETCH) to the
// control word. Reset forces the whole word to zero in the same cycle.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMM_SH;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.illegal_op = (decode_target(opcode) == S_FETCH);
        end
        S_MEMADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMREAD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        // andi/ori zero-extend and use the logic ALU op; addi sign-extends and adds.
        S_IMMEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.ext_zero  = is_imm_logic(opcode);
          ctrl.alu_op    = is_imm_logic(opcode) ? ALUOP_LOGIC : ALUOP_ADD;
        end
        S_IMMWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.ext_zero  = is_imm_logic(opcode);
          ctrl.alu_op    = is_imm_logic(opcode) ? ALUOP_LOGIC : ALUOP_ADD;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register and next-state logic; the
// control outputs come from multicycle_control_decode.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Branch resolution is gated outside via pc_write_cond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_target(opcode);
      S_MEMADDR:  state_d = (opcode == OP_LW) ? S_MEMREAD :
                            (opcode == OP_SW) ? S_MEMWRITE : S_FETCH;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IMMWB: state_d = S_FETCH;
      S_EXEC:     state_d = S_RWB;
      S_IMMEXEC:  state_d = S_IMMWB;
      default:    state_d = S_FETCH;
    endcase
  end

  multicycle_control_decode u_decode (
    .reset     (reset),
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign ext_zero      = ctrl.ext_zero;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_b     = ctrl.alu_src_b;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus hand-written
// sequences for long memory stalls and reset during a wait.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, mem_ready, zero;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, ext_zero, illegal_op;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .ext_zero(ext_zero), .pc_source(pc_source),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .illegal_op(illegal_op), .state(state)
  );

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_write, reg_dst, alu_src_a, ext_zero}_{pc_source}_{alu_op}_{alu_src_b}_{illegal_op}
  logic [17:0] act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, reg_dst, alu_src_a, ext_zero,
                pc_source, alu_op, alu_src_b, illegal_op};

  localparam logic [17:0] C_ZERO   = 18'b00000000000_00_00_00_0;
  localparam logic [17:0] C_FRDY   = 18'b10010100000_00_00_01_0;
  localparam logic [17:0] C_FWAIT  = 18'b00010000000_00_00_01_0;
  localparam logic [17:0] C_DEC    = 18'b00000000000_00_00_11_0;
  localparam logic [17:0] C_DECILL = 18'b00000000000_00_00_11_1;
  localparam logic [17:0] C_MADDR  = 18'b00000000010_00_00_10_0;
  localparam logic [17:0] C_MRD    = 18'b00110000000_00_00_00_0;
  localparam logic [17:0] C_MWR    = 18'b00101000000_00_00_00_0;
  localparam logic [17:0] C_MWB    = 18'b00000011000_00_00_00_0;
  localparam logic [17:0] C_EXEC   = 18'b00000000010_00_10_00_0;
  localparam logic [17:0] C_RWB    = 18'b00000001100_00_00_00_0;
  localparam logic [17:0] C_BR     = 18'b01000000010_01_01_00_0;
  localparam logic [17:0] C_JMP    = 18'b10000000000_10_00_00_0;
  localparam logic [17:0] C_IEXL   = 18'b00000000011_00_11_10_0;
  localparam logic [17:0] C_IEXA   = 18'b00000000010_00_00_10_0;
  localparam logic [17:0] C_IWBL   = 18'b00000001001_00_11_00_0;
  localparam logic [17:0] C_IWBA   = 18'b00000001000_00_00_00_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [5:0] o, logic m, logic zz,
                              logic [3:0] s, logic [17:0] c);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.z = zz; v.st = s; v.ctl = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] exp_st, input logic [17:0] exp_ctl);
    n_tests++;
    if (state !== exp_st || act !== exp_ctl) begin
      n_fail++;
      $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, state, act, exp_st, exp_ctl);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic m, input logic zz);
    @(negedge clk);
    reset = r; opcode = o; mem_ready = m; zero = zz;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0; zero = 1'b0;

    // reset with mem_ready=1 must still hold every control low
    tbl.push_back(mk(1, 6'b000000, 1, 0, 4'd0, C_ZERO));
    tbl.push_back(mk(1, 6'b000000, 1, 0, 4'd0, C_ZERO));
    // R-type
    tbl.push_back(mk(0, 6'b000000, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 4'd6, C_EXEC));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 4'd7, C_RWB));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 4'd0, C_FWAIT));
    // lw with 3-cycle stall
    tbl.push_back(mk(0, 6'b100011, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b100011, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b100011, 0, 0, 4'd2, C_MADDR));
    tbl.push_back(mk(0, 6'b100011, 0, 0, 4'd3, C_MRD));
    tbl.push_back(mk(0, 6'b100011, 0, 0, 4'd3, C_MRD));
    tbl.push_back(mk(0, 6'b100011, 0, 0, 4'd3, C_MRD));
    tbl.push_back(mk(0, 6'b100011, 1, 0, 4'd3, C_MRD));
    tbl.push_back(mk(0, 6'b100011, 1, 0, 4'd4, C_MWB));
    // ori then addi
    tbl.push_back(mk(0, 6'b001101, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b001101, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b001101, 1, 0, 4'd10, C_IEXL));
    tbl.push_back(mk(0, 6'b001101, 1, 0, 4'd11, C_IWBL));
    tbl.push_back(mk(0, 6'b001000, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b001000, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b001000, 1, 0, 4'd10, C_IEXA));
    tbl.push_back(mk(0, 6'b001000, 1, 0, 4'd11, C_IWBA));
    // beq with zero=0, then zero=1: controller output identical
    tbl.push_back(mk(0, 6'b000100, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b000100, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b000100, 1, 0, 4'd8, C_BR));
    tbl.push_back(mk(0, 6'b000100, 1, 1, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b000100, 1, 1, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b000100, 1, 1, 4'd8, C_BR));
    // jump
    tbl.push_back(mk(0, 6'b000010, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 4'd9, C_JMP));
    // illegal opcode: single-cycle pulse, back to FETCH
    tbl.push_back(mk(0, 6'b111111, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b111111, 1, 0, 4'd1, C_DECILL));
    tbl.push_back(mk(0, 6'b111111, 0, 0, 4'd0, C_FWAIT));
    // sw, reset mid-MEMWRITE
    tbl.push_back(mk(0, 6'b101011, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b101011, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b101011, 0, 0, 4'd2, C_MADDR));
    tbl.push_back(mk(0, 6'b101011, 0, 0, 4'd5, C_MWR));
    tbl.push_back(mk(1, 6'b101011, 0, 0, 4'd0, C_ZERO));
    tbl.push_back(mk(0, 6'b101011, 0, 0, 4'd0, C_FWAIT));
    // sw completing normally
    tbl.push_back(mk(0, 6'b101011, 1, 0, 4'd0, C_FRDY));
    tbl.push_back(mk(0, 6'b101011, 1, 0, 4'd1, C_DEC));
    tbl.push_back(mk(0, 6'b101011, 0, 0, 4'd2, C_MADDR));
    tbl.push_back(mk(0, 6'b101011, 1, 0, 4'd5, C_MWR));
    tbl.push_back(mk(0, 6'b101011, 0, 0, 4'd0, C_FWAIT));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].z);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctl);
    end

    // Long MEMREAD stall: outputs must stay put, no timeout.
    drive(0, 6'b100011, 1, 0); check("lw2_fetch", 4'd0, C_FRDY);
    drive(0, 6'b100011, 0, 0); check("lw2_decode", 4'd1, C_DEC);
    drive(0, 6'b100011, 0, 0); check("lw2_maddr", 4'd2, C_MADDR);
    for (int k = 0; k < 20; k++) begin
      drive(0, 6'b100011, 0, 0);
      check($sformatf("lw2_stall%0d", k), 4'd3, C_MRD);
    end
    // Reset mid-MEMREAD with mem_ready high: no read completion, back to FETCH.
    drive(1, 6'b100011, 1, 0); check("lw2_rst", 4'd0, C_ZERO);
    drive(0, 6'b100011, 0, 0); check("lw2_after_rst", 4'd0, C_FWAIT);
    drive(0, 6'b100011, 1, 0); check("lw2_refetch", 4'd0, C_FRDY);
    drive(0, 6'b100011, 0, 0); check("lw2_redecode", 4'd1, C_DEC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
